// File: rtl/debug_clock_controller_pkg.sv
// ----------------------------------------------------------------------------
// debug_clock_controller_pkg
//   Shared definitions for the debug clock sequencer. The debug command decoder
//   imports the same package, so the opcode values here are the wire encoding
//   used on cmd_op.
//
//   cmd_op_t    host command opcodes (HALT, RUN, STEP, SET_DIV)
//   state_t     sequencer states (HALTED, RUNNING, STEPPING)
//   ctrl_t      registered per-state controls driven toward the divider/host
//   state_ctrl  maps a state to the control levels it presents
// ----------------------------------------------------------------------------
package debug_clock_controller_pkg;

   typedef enum logic [1:0] {
      CMD_HALT    = 2'd0,
      CMD_RUN     = 2'd1,
      CMD_STEP    = 2'd2,
      CMD_SET_DIV = 2'd3
   } cmd_op_t;

   typedef enum logic [1:0] {
      ST_HALTED   = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2
   } state_t;

   typedef struct packed {
      logic ready;       // host may issue a command
      logic option;      // divider mode: 0 pulse, 1 auto
      logic out_enable;  // divider output enable
      logic busy;        // a STEP is in progress
   } ctrl_t;

   // Reset levels: ready stays low for one cycle after reset release.
   localparam ctrl_t CTRL_RESET = '{ready: 1'b0, option: 1'b0, out_enable: 1'b0, busy: 1'b0};

   // Smallest divider value the clock divider can produce a clock from.
   localparam int MIN_DIV = 2;

   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = CTRL_RESET;
      case (s)
         ST_RUNNING: begin
            c.ready      = 1'b1;
            c.option     = 1'b1;
            c.out_enable = 1'b1;
         end
         ST_STEPPING: begin
            c.out_enable = 1'b1;
            c.busy       = 1'b1;
         end
         default: begin
            c.ready = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/debug_step_timer.sv
// ----------------------------------------------------------------------------
// debug_step_timer
//   Loadable down-counter that spaces the divider pulse strobes H cycles apart.
//   Loading value H-1 makes tick assert H cycles after the load edge; the
//   counter then holds at zero until reloaded.
//
//   clk         system clock
//   reset       asynchronous, active-low reset
//   load        load load_value this cycle (takes priority over counting)
//   load_value  initial count
//   tick        count is zero: the next pulse is due at this edge
//   near        count is one: one cycle before tick
// ----------------------------------------------------------------------------
module debug_step_timer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tick,
   output logic             near
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - ONE;
      end
   end

   assign tick = (count == '0);
   assign near = (count == ONE);

endmodule

// File: rtl/debug_clock_controller.sv
// ----------------------------------------------------------------------------
// debug_clock_controller
//   Turns host debug commands into controls for the core's clock divider.
//   RUN puts the divider in free-running auto mode, HALT stops it, SET_DIV
//   changes its period, and STEP N emits exactly N target-clock cycles as
//   2N pulse-mode strobes spaced H = max(divider/2, 1) cycles apart.
//
//   clk             system clock
//   reset           asynchronous, active-low reset
//   cmd_valid       command present
//   cmd_ready       command accepted when cmd_valid & cmd_ready
//   cmd_op          0 HALT, 1 RUN, 2 STEP, 3 SET_DIV
//   cmd_arg         STEP: cycle count N; SET_DIV: new divider
//   abort           synchronous; forces HALTED, beats a same-cycle command
//   div_option      divider mode: 0 pulse, 1 auto
//   div_out_enable  divider output enable
//   div_divider     divider period
//   div_pulse       one-cycle strobes toggling the divider's pulse flip-flop
//   busy            high while stepping
//   step_done       one-cycle strobe when a STEP completes (not on abort)
//   steps_done      target cycles completed in the current/last STEP
// ----------------------------------------------------------------------------
module debug_clock_controller
   import debug_clock_controller_pkg::*;
#(
   parameter int COUNTER_BITS = 32,
   parameter int DEFAULT_DIV  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [COUNTER_BITS-1:0] cmd_arg,
   input  logic                    abort,
   output logic                    div_option,
   output logic                    div_out_enable,
   output logic [COUNTER_BITS-1:0] div_divider,
   output logic                    div_pulse,
   output logic                    busy,
   output logic                    step_done,
   output logic [COUNTER_BITS-1:0] steps_done
);

   localparam logic [COUNTER_BITS-1:0] ONE      = COUNTER_BITS'(1);
   localparam logic [COUNTER_BITS-1:0] DIV_MIN  = COUNTER_BITS'(MIN_DIV);
   localparam logic [COUNTER_BITS:0]   EDGE_ONE = (COUNTER_BITS + 1)'(1);

   state_t                  state;
   ctrl_t                   ctrl;
   logic                    phase;       // mirrors the divider's pulse flip-flop
   logic [COUNTER_BITS:0]   edges_left;  // scheduled pulses still to issue; 2N needs one extra bit
   logic [COUNTER_BITS-1:0] half;
   logic [COUNTER_BITS:0]   edges_init;
   cmd_op_t                 op;
   logic                    accept;
   logic                    step_start;
   logic                    step_zero;
   logic                    in_step;
   logic                    sched_pulse;
   logic                    finish;
   logic                    timer_tick;
   logic                    timer_near;

   // abort wins over a same-cycle command, so the handshake is masked by it.
   assign cmd_ready      = ctrl.ready & ~abort;
   assign div_option     = ctrl.option;
   assign div_out_enable = ctrl.out_enable;
   assign busy           = ctrl.busy;

   assign op         = cmd_op_t'(cmd_op);
   assign half       = ((div_divider >> 1) == '0) ? ONE : (div_divider >> 1);
   assign accept     = cmd_valid & cmd_ready;
   assign step_start = accept && (op == CMD_STEP) && (cmd_arg != '0);
   assign step_zero  = accept && (op == CMD_STEP) && (cmd_arg == '0);

   // With phase high the target clock is currently high: one leading pulse
   // brings it low first, so all 2N scheduled pulses remain after it.
   // Otherwise the pulse issued at entry is the first of the 2N.
   assign edges_init = phase ? {cmd_arg, 1'b0} : ({cmd_arg, 1'b0} - EDGE_ONE);

   assign in_step     = (state == ST_STEPPING) && !abort;
   assign sched_pulse = in_step && timer_tick && (edges_left != '0);

   // The step ends H-1 cycles after the last pulse: with H = 1 that is the
   // last pulse's own edge, otherwise the edge where the timer reads one.
   assign finish = in_step &&
                   ((sched_pulse && (edges_left == EDGE_ONE) && (half == ONE)) ||
                    ((edges_left == '0) && timer_near));

   debug_step_timer #(
      .WIDTH(COUNTER_BITS)
   ) u_step_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (step_start | sched_pulse),
      .load_value(half - ONE),
      .tick      (timer_tick),
      .near      (timer_near)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_HALTED;
         ctrl        <= CTRL_RESET;
         phase       <= 1'b0;
         edges_left  <= '0;
         div_divider <= COUNTER_BITS'(DEFAULT_DIV);
         div_pulse   <= 1'b0;
         step_done   <= 1'b0;
         steps_done  <= '0;
      end else begin
         // Refresh the controls from the current state; a transition below
         // overrides this with the controls of the new state.
         ctrl      <= state_ctrl(state);
         div_pulse <= step_start | sched_pulse;
         step_done <= step_zero | finish;

         if (step_start | sched_pulse) begin
            phase <= ~phase;
         end

         if (step_start) begin
            edges_left <= edges_init;
         end else if (sched_pulse) begin
            edges_left <= edges_left - EDGE_ONE;
         end

         // A pulse issued while the target clock is high is a falling edge,
         // which closes one target cycle.
         if (step_start | step_zero) begin
            steps_done <= '0;
         end else if (sched_pulse && phase) begin
            steps_done <= steps_done + ONE;
         end

         if (abort) begin
            state <= ST_HALTED;
            ctrl  <= state_ctrl(ST_HALTED);
         end else begin
            case (state)
               ST_STEPPING: begin
                  if (finish) begin
                     state <= ST_HALTED;
                     ctrl  <= state_ctrl(ST_HALTED);
                  end
               end
               default: begin
                  if (accept) begin
                     case (op)
                        CMD_HALT: begin
                           state <= ST_HALTED;
                           ctrl  <= state_ctrl(ST_HALTED);
                        end
                        CMD_RUN: begin
                           state <= ST_RUNNING;
                           ctrl  <= state_ctrl(ST_RUNNING);
                        end
                        CMD_STEP: begin
                           if (step_start) begin
                              state <= ST_STEPPING;
                              ctrl  <= state_ctrl(ST_STEPPING);
                           end else begin
                              state <= ST_HALTED;
                              ctrl  <= state_ctrl(ST_HALTED);
                           end
                        end
                        CMD_SET_DIV: begin
                           div_divider <= (cmd_arg < DIV_MIN) ? DIV_MIN : cmd_arg;
                        end
                     endcase
                  end
               end
            endcase
         end
      end
   end

endmodule
